decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count; the highest index reads as zero.
REQ-003 The block SHALL have parameter BYP_STAGES, default 3, meaning downstream bypass sources, index 0 nearest.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port if_valid, input, 1 bit, marking fetch output valid.
REQ-007 The block SHALL have port if_pc, input, XLEN bits, carrying PC+4 of the fetched instruction.
REQ-008 The block SHALL have port if_ir, input, 32 bits, carrying the fetched instruction.
REQ-009 The block SHALL have port stall, output, 1 bit, telling fetch to hold.
REQ-010 The block SHALL have port redirect, output, 1 bit, signalling a taken branch or jump.
REQ-011 The block SHALL have port redirect_addr, output, XLEN bits, carrying the redirect target.
REQ-012 The block SHALL have ports byp_valid (input, BYP_STAGES bits) and byp_ld_pend (input, BYP_STAGES bits), the per-stage result-valid and load-data-not-ready flags.
REQ-013 The block SHALL have ports byp_rc (input, 5*BYP_STAGES bits) and byp_data (input, XLEN*BYP_STAGES bits), the per-stage destination register and result.
REQ-014 The block SHALL have ports rf_we (input, 1 bit), rf_wa (input, 5 bits) and rf_wd (input, XLEN bits), the write-back port.
REQ-015 The block SHALL have outputs ex_valid (1 bit), ex_pc (XLEN), ex_ir (32), ex_a (XLEN), ex_b (XLEN), ex_d (XLEN) and ex_illegal (1 bit), all registered.

Function
REQ-016 Opcode map, opcode=ir[31:26]:
- 011000 LD, 011001 ST, 011011 JMP, 011100 BEQ, 011101 BNE, 011111 LDR
- 100xxx ALU; 110xxx/111xxx ALU-constant
- Legal ALU codes are exactly 100000/001/100/101/110, 101000-101110, 110000/001/100/101/110 and 111000-111110.
- All other codes are illegal.
REQ-017 Fields SHALL be Rc=ir[25:21], Ra=ir[20:16], Rb=ir[15:11] and C=ir[15:0], with SXT meaning sign-extension of C.
REQ-018 The D-stage register (d_valid, d_pc, d_ir) SHALL load if_valid/if_pc/if_ir each edge unless stall=1, in which case it holds.
REQ-019 On an edge where redirect=1, the D-stage SHALL load d_valid=0, annulling the wrong-path instruction.
REQ-020 Source 1 SHALL be Ra; source 2 SHALL be Rc for ST and Rb otherwise.
REQ-021 Operand resolution SHALL use the lowest-index stage i with byp_valid[i]=1 and byp_rc[i]=source, whose byp_data[i] supplies the operand.
REQ-022 With no bypass match, a write-back hit (rf_we=1, rf_wa=source) SHALL supply rf_wd (write-through); otherwise the register file SHALL supply the operand.
REQ-023 The zero register SHALL always read 0 with no bypass, and writes to it SHALL be ignored.
REQ-024 stall SHALL be asserted (combinational) when d_valid=1 and the winning match for either used source has byp_ld_pend=1.
- Unused sources are ignored: LD/LDR/ALU-constant ignore source 2; JMP/BEQ/BNE/LDR ignore source 1 except the branch test and JMP target.
REQ-025 While stalled, the next edge SHALL load ex_valid=0, ex_ir=0x83FFF800 (NOP) and ex_illegal=0.
REQ-026 redirect SHALL be asserted when d_valid=1, stall=0 and one of the following holds:
- JMP
- BEQ with operand1==0
- BNE with operand1!=0
REQ-027 redirect_addr SHALL be operand1 with bits[1:0] cleared for JMP, and d_pc+4*SXT(C) for branches.
REQ-028 When not stalled, the next edge SHALL load the execute registers:
- ex_valid=d_valid, ex_pc=d_pc, ex_ir=d_ir (NOP when d_valid=0)
- ex_a = d_pc+4*SXT(C) for LDR, else operand1
- ex_b = SXT(C) for LD, ST and constant ops, else operand2
- ex_d = operand2
- ex_illegal=1 for illegal opcodes
REQ-029 Latency SHALL be: an instruction accepted at edge N appears on ex_* after edge N+1, plus one cycle per stall cycle.
REQ-030 All address arithmetic SHALL be modulo 2^XLEN.

Reset
REQ-031 While rst_n=0, regardless of clk, the following SHALL hold: d_valid=0, d_pc=0, d_ir=NOP, ex_valid=0, ex_pc=0, ex_ir=NOP, ex_a=ex_b=ex_d=0 and ex_illegal=0.
REQ-032 While rst_n=0, stall and redirect SHALL be 0.
REQ-033 The register file contents SHALL not be reset.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction.
REQ-035 The first edge after deassertion SHALL capture fetch normally.

Verification
REQ-036 The bench SHALL cover: R1=5 via write-back, ADDC R2,R1,3 issued -> two edges later ex_a=5, ex_b=3, ex_valid=1.
REQ-037 The bench SHALL cover: ADD R3,R1,R2 with byp stage0 rc=1 data=7 and stage2 rc=1 data=9 -> ex_a=7 (nearest wins).
REQ-038 The bench SHALL cover: stage0 rc=2, ld_pend=1 while D holds SUB using R2 -> stall=1 for exactly the cycles ld_pend stays 1, ex_ir=0x83FFF800, ex_valid=0, d_ir unchanged; operand correct on release.
REQ-039 The bench SHALL cover: BEQ R31, C=-2, d_pc=0x100 -> redirect=1, redirect_addr=0xF8; the next D-stage instruction is annulled (ex_valid=0 one cycle later).
REQ-040 The bench SHALL cover: opcode 000000 -> ex_illegal=1; writing R31=0xFFFF then reading R31 -> operand 0.
REQ-041 The bench SHALL cover: rst_n pulsed low mid-stall, asynchronously to clk -> all outputs at reset values immediately.

Source files
------------

// File: rtl/decode_pipe_if.sv
// Decode-stage bundle: fetch handshake, bypass network, write-back port and execute-stage outputs.
interface decode_pipe_if #(
    parameter int XLEN       = 32,
    parameter int BYP_STAGES = 3
);
    logic                                 if_valid;
    logic [XLEN-1:0]                      if_pc;
    logic [31:0]                          if_ir;
    logic                                 stall;
    logic                                 redirect;
    logic [XLEN-1:0]                      redirect_addr;
    logic [BYP_STAGES-1:0]                byp_valid;
    logic [BYP_STAGES-1:0]                byp_ld_pend;
    logic [BYP_STAGES-1:0][4:0]           byp_rc;
    logic [BYP_STAGES-1:0][XLEN-1:0]      byp_data;
    logic                                 rf_we;
    logic [4:0]                           rf_wa;
    logic [XLEN-1:0]                      rf_wd;
    logic                                 ex_valid;
    logic [XLEN-1:0]                      ex_pc;
    logic [31:0]                          ex_ir;
    logic [XLEN-1:0]                      ex_a;
    logic [XLEN-1:0]                      ex_b;
    logic [XLEN-1:0]                      ex_d;
    logic                                 ex_illegal;

    modport master (
        output if_valid, if_pc, if_ir, byp_valid, byp_ld_pend, byp_rc, byp_data,
               rf_we, rf_wa, rf_wd,
        input  stall, redirect, redirect_addr,
               ex_valid, ex_pc, ex_ir, ex_a, ex_b, ex_d, ex_illegal
    );

    modport slave (
        input  if_valid, if_pc, if_ir, byp_valid, byp_ld_pend, byp_rc, byp_data,
               rf_we, rf_wa, rf_wd,
        output stall, redirect, redirect_addr,
               ex_valid, ex_pc, ex_ir, ex_a, ex_b, ex_d, ex_illegal
    );
endinterface

// File: rtl/decode_pipe.sv
// Decode stage: register read with bypass/write-through, load-use stall, branch resolution
// and the execute-stage pipeline register.
module decode_opnd #(
    parameter int         XLEN       = 32,
    parameter int         BYP_STAGES = 3,
    parameter logic [4:0] ZREG       = 5'd31
) (
    input  logic [4:0]                      src,
    input  logic [XLEN-1:0]                 rf_val,
    input  logic [BYP_STAGES-1:0]           byp_valid,
    input  logic [BYP_STAGES-1:0]           byp_ld_pend,
    input  logic [BYP_STAGES-1:0][4:0]      byp_rc,
    input  logic [BYP_STAGES-1:0][XLEN-1:0] byp_data,
    input  logic                            rf_we,
    input  logic [4:0]                      rf_wa,
    input  logic [XLEN-1:0]                 rf_wd,
    output logic [XLEN-1:0]                 opnd,
    output logic                            pend
);
    always_comb begin
        opnd = rf_val;
        pend = 1'b0;
        if (rf_we && rf_wa == src)
            opnd = rf_wd;
        // walk farthest to nearest so the lowest-index match is the one left standing
        for (int i = BYP_STAGES - 1; i >= 0; i--) begin
            if (byp_valid[i] && byp_rc[i] == src) begin
                opnd = byp_data[i];
                pend = byp_ld_pend[i];
            end
        end
        if (src >= ZREG) begin
            opnd = '0;
            pend = 1'b0;
        end
    end
endmodule

module decode_pipe #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int BYP_STAGES = 3
) (
    input logic         clk,
    input logic         rst_n,
    decode_pipe_if.slave bus
);
    localparam logic [31:0] NOP  = 32'h83FF_F800;
    localparam logic [4:0]  ZREG = 5'(NREG - 1);

    logic [XLEN-1:0] rf [NREG];

    logic            d_valid;
    logic [XLEN-1:0] d_pc;
    logic [31:0]     d_ir;

    logic [5:0]           op;
    logic [XLEN-1:0]      sxt, br_tgt;
    logic                 is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr, is_alu_r, is_const;
    logic                 legal, use1, use2, stall, redirect;
    logic [1:0][4:0]      src;
    logic [1:0][XLEN-1:0] rf_val, opnd;
    logic [1:0]           pend;

    always_comb begin
        op       = d_ir[31:26];
        sxt      = {{(XLEN-16){d_ir[15]}}, d_ir[15:0]};
        br_tgt   = d_pc + (sxt << 2);
        is_ld    = op == 6'b011000;
        is_st    = op == 6'b011001;
        is_jmp   = op == 6'b011011;
        is_beq   = op == 6'b011100;
        is_bne   = op == 6'b011101;
        is_ldr   = op == 6'b011111;
        is_alu_r = op[5:4] == 2'b10;
        is_const = op[5:4] == 2'b11;
        // x0x groups allow 000/001/100/101/110, x1x groups allow 000-110
        legal    = is_ld | is_st | is_jmp | is_beq | is_bne | is_ldr |
                   (op[5] & (op[3] ? (op[2:0] != 3'b111)
                                   : (op[1:0] != 2'b11 && op[2:0] != 3'b010)));
        use1     = legal & ~is_ldr;
        use2     = legal & (is_st | is_alu_r);
        src[0]   = d_ir[20:16];
        src[1]   = is_st ? d_ir[25:21] : d_ir[15:11];
    end

    for (genvar k = 0; k < 2; k++) begin : g_src
        assign rf_val[k] = rf[src[k]];
        decode_opnd #(.XLEN(XLEN), .BYP_STAGES(BYP_STAGES), .ZREG(ZREG)) u_opnd (
            .src        (src[k]),
            .rf_val     (rf_val[k]),
            .byp_valid  (bus.byp_valid),
            .byp_ld_pend(bus.byp_ld_pend),
            .byp_rc     (bus.byp_rc),
            .byp_data   (bus.byp_data),
            .rf_we      (bus.rf_we),
            .rf_wa      (bus.rf_wa),
            .rf_wd      (bus.rf_wd),
            .opnd       (opnd[k]),
            .pend       (pend[k])
        );
    end

    always_comb begin
        stall    = d_valid & ((use1 & pend[0]) | (use2 & pend[1]));
        redirect = d_valid & ~stall &
                   (is_jmp | (is_beq & (opnd[0] == '0)) | (is_bne & (opnd[0] != '0)));
    end

    assign bus.stall         = stall;
    assign bus.redirect      = redirect;
    assign bus.redirect_addr = is_jmp ? {opnd[0][XLEN-1:2], 2'b00} : br_tgt;

    always_ff @(posedge clk) begin
        if (bus.rf_we && bus.rf_wa < ZREG)
            rf[bus.rf_wa] <= bus.rf_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_pc    <= '0;
            d_ir    <= NOP;
        end else if (!stall) begin
            d_valid <= bus.if_valid & ~redirect;
            d_pc    <= bus.if_pc;
            d_ir    <= bus.if_ir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc      <= '0;
            bus.ex_ir      <= NOP;
            bus.ex_a       <= '0;
            bus.ex_b       <= '0;
            bus.ex_d       <= '0;
            bus.ex_illegal <= 1'b0;
        end else if (stall) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_ir      <= NOP;
            bus.ex_illegal <= 1'b0;
        end else begin
            bus.ex_valid   <= d_valid;
            bus.ex_pc      <= d_pc;
            bus.ex_ir      <= d_valid ? d_ir : NOP;
            bus.ex_a       <= is_ldr ? br_tgt : opnd[0];
            bus.ex_b       <= (is_ld | is_st | is_const) ? sxt : opnd[1];
            bus.ex_d       <= opnd[1];
            bus.ex_illegal <= d_valid & ~legal;
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: hand-encoded instructions with hand-computed operands.
module tb_decode_pipe;
    localparam logic [31:0] NOP = 32'h83FF_F800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    decode_pipe_if #(.XLEN(32), .BYP_STAGES(3)) bus ();

    decode_pipe #(.XLEN(32), .NREG(32), .BYP_STAGES(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ir);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_ir    = ir;
    endtask

    initial begin
        bus.if_valid    = 1'b0;
        bus.if_pc       = '0;
        bus.if_ir       = '0;
        bus.byp_valid   = '0;
        bus.byp_ld_pend = '0;
        bus.byp_rc      = '0;
        bus.byp_data    = '0;
        bus.rf_we       = 1'b0;
        bus.rf_wa       = '0;
        bus.rf_wd       = '0;

        #12;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_ir", bus.ex_ir, NOP);
        chk("rst_d_ir", dut.d_ir, NOP);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        rst_n = 1'b1;

        // R1=5 by write-back while ADDC R2,R1,3 enters D
        bus.rf_we = 1'b1; bus.rf_wa = 5'd1; bus.rf_wd = 32'd5;
        fetch(32'h104, 32'hC041_0003);
        tick();
        bus.rf_we = 1'b0; bus.if_valid = 1'b0;
        tick();
        chk("addc_valid", 32'(bus.ex_valid), 32'd1);
        chk("addc_a", bus.ex_a, 32'd5);
        chk("addc_b", bus.ex_b, 32'd3);
        chk("addc_pc", bus.ex_pc, 32'h104);

        // ST R2,-4(R1) with R2=0x22 arriving by write-through
        fetch(32'h108, 32'h6441_FFFC);
        tick();
        bus.if_valid = 1'b0;
        bus.rf_we = 1'b1; bus.rf_wa = 5'd2; bus.rf_wd = 32'h22;
        tick();
        bus.rf_we = 1'b0;
        chk("st_a", bus.ex_a, 32'd5);
        chk("st_b", bus.ex_b, 32'hFFFF_FFFC);
        chk("st_d", bus.ex_d, 32'h22);
        chk("st_illegal", 32'(bus.ex_illegal), 32'd0);

        // ADD R3,R1,R2: nearest bypass stage wins
        fetch(32'h10C, 32'h8061_1000);
        tick();
        bus.if_valid = 1'b0;
        bus.byp_valid = 3'b101;
        bus.byp_rc[0] = 5'd1; bus.byp_data[0] = 32'd7;
        bus.byp_rc[2] = 5'd1; bus.byp_data[2] = 32'd9;
        tick();
        bus.byp_valid = '0;
        chk("add_byp_a", bus.ex_a, 32'd7);
        chk("add_rf_b", bus.ex_b, 32'h22);

        // SUB R4,R2,R1 blocked by a pending load into R2 for two cycles
        fetch(32'h110, 32'h8482_0800);
        tick();
        fetch(32'h114, 32'hC041_0003);
        bus.byp_valid = 3'b001; bus.byp_rc[0] = 5'd2; bus.byp_data[0] = 32'hAA;
        bus.byp_ld_pend = 3'b001;
        #1;
        chk("stall_on", 32'(bus.stall), 32'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("stall_held", 32'(bus.stall), 32'd1);
            chk("stall_ex_valid", 32'(bus.ex_valid), 32'd0);
            chk("stall_ex_ir", bus.ex_ir, NOP);
            chk("stall_d_ir", dut.d_ir, 32'h8482_0800);
        end
        bus.byp_ld_pend = '0;
        #1;
        chk("stall_off", 32'(bus.stall), 32'd0);
        tick();
        bus.if_valid = 1'b0;
        bus.byp_valid = '0;
        chk("sub_valid", 32'(bus.ex_valid), 32'd1);
        chk("sub_ir", bus.ex_ir, 32'h8482_0800);
        chk("sub_a", bus.ex_a, 32'hAA);
        chk("sub_b", bus.ex_b, 32'd5);
        tick();
        chk("after_stall_pc", bus.ex_pc, 32'h114);

        // BEQ R31,-2 at d_pc=0x100 taken; wrong-path fetch annulled
        fetch(32'h100, 32'h701F_FFFE);
        tick();
        fetch(32'h104, 32'h8061_1000);
        #1;
        chk("beq_redirect", 32'(bus.redirect), 32'd1);
        chk("beq_addr", bus.redirect_addr, 32'hF8);
        tick();
        bus.if_valid = 1'b0;
        chk("beq_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("annul_d_valid", 32'(dut.d_valid), 32'd0);
        tick();
        chk("annul_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("annul_ex_ir", bus.ex_ir, NOP);

        // JMP R1 (R1=5): low bits cleared
        fetch(32'h120, 32'h6C01_0000);
        tick();
        bus.if_valid = 1'b0;
        #1;
        chk("jmp_redirect", 32'(bus.redirect), 32'd1);
        chk("jmp_addr", bus.redirect_addr, 32'h4);
        tick();

        // opcode 000000 is illegal
        fetch(32'h130, 32'h0000_0000);
        tick();
        bus.if_valid = 1'b0;
        tick();
        chk("illegal_flag", 32'(bus.ex_illegal), 32'd1);
        chk("illegal_valid", 32'(bus.ex_valid), 32'd1);

        // R31 write ignored, bypass on R31 ignored
        bus.rf_we = 1'b1; bus.rf_wa = 5'd31; bus.rf_wd = 32'hFFFF;
        tick();
        bus.rf_we = 1'b0;
        fetch(32'h140, 32'h80BF_F800);
        tick();
        bus.if_valid = 1'b0;
        bus.byp_valid = 3'b001; bus.byp_rc[0] = 5'd31; bus.byp_data[0] = 32'h1234;
        tick();
        bus.byp_valid = '0;
        chk("r31_a", bus.ex_a, 32'd0);
        chk("r31_b", bus.ex_b, 32'd0);

        // LDR at d_pc=0x200, C=2
        fetch(32'h200, 32'h7C60_0002);
        tick();
        bus.if_valid = 1'b0;
        tick();
        chk("ldr_a", bus.ex_a, 32'h208);

        // async reset in the middle of a stall
        fetch(32'h210, 32'h8482_0800);
        tick();
        bus.if_valid = 1'b0;
        bus.byp_valid = 3'b001; bus.byp_rc[0] = 5'd2; bus.byp_ld_pend = 3'b001;
        tick();
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 32'd0);
        chk("arst_redirect", 32'(bus.redirect), 32'd0);
        chk("arst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("arst_ex_ir", bus.ex_ir, NOP);
        chk("arst_ex_a", bus.ex_a, 32'd0);
        chk("arst_ex_pc", bus.ex_pc, 32'd0);
        chk("arst_d_valid", 32'(dut.d_valid), 32'd0);
        chk("arst_d_ir", dut.d_ir, NOP);
        bus.byp_valid = '0; bus.byp_ld_pend = '0;
        #3 rst_n = 1'b1;
        fetch(32'h300, 32'hC041_0003);
        tick();
        bus.if_valid = 1'b0;
        chk("post_rst_d_valid", 32'(dut.d_valid), 32'd1);
        tick();
        chk("post_rst_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("post_rst_ex_pc", bus.ex_pc, 32'h300);
        chk("post_rst_rf_kept", bus.ex_a, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
